// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
//   Scans a 4x4 active-low key matrix one row at a time. It senses the
//   columns, debounces whole 16-bit frames and reports single key presses
//   as a 4-bit code with a one-cycle strobe.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   clr        synchronous active-low clear (same effect as rst, on the edge)
//   col_in     column sense, active-low, asynchronous to clk
//   row_out    row drive, active-low one-hot (1110, 1101, 1011, 0111, ...)
//   key_code   code (row*4+col) of the last accepted key
//   key_valid  one-cycle pulse when a new single key is accepted
//   key_held   high while the accepted key stays debounced-pressed
//   multi_err  high while the debounced frame has two or more keys pressed
module keypad_matrix_scanner #(
   parameter int SCAN_DIV = 24000,
   parameter int DEBOUNCE = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       multi_err
);

   localparam int               CNT_W      = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
   localparam logic [3:0]       STABLE_MAX = 4'(DEBOUNCE);

   typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_BLOCKED} state_t;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
      return n;
   endfunction

   // Lowest set bit wins; only called when exactly one bit is set.
   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
      return idx;
   endfunction

   logic [3:0]       col_meta_q, col_meta_d, col_s_q, col_s_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       row_q, row_d;
   logic [3:0]       row_out_q, row_out_d;
   logic [15:0]      snap_q, snap_d;
   logic [15:0]      frame_cur_q, frame_cur_d;
   logic [15:0]      frame_prev_q, frame_prev_d;
   logic             frame_end_q, frame_end_d;
   logic [3:0]       stable_q, stable_d;
   logic             accept_q, accept_d;
   state_t           state_q, state_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             key_held_q, key_held_d;
   logic             multi_err_q, multi_err_d;
   logic             tick;
   logic [4:0]       pc;

   always_comb begin
      col_meta_d   = col_in;
      col_s_d      = col_meta_q;
      cnt_d        = cnt_q;
      row_d        = row_q;
      snap_d       = snap_q;
      frame_cur_d  = frame_cur_q;
      frame_end_d  = 1'b0;
      frame_prev_d = frame_prev_q;
      stable_d     = stable_q;
      accept_d     = 1'b0;
      state_d      = state_q;
      key_code_d   = key_code_q;
      key_valid_d  = 1'b0;
      pc           = popcount16(frame_prev_q);
      tick         = (cnt_q == CNT_LAST);

      // Sample the driven row at the end of its step, then move on.
      if (tick) begin
         cnt_d = '0;
         snap_d[{row_q, 2'b00} +: 4] = ~col_s_q;
         row_d = row_q + 2'd1;
         // Latch the frame including the row-3 bits sampled on this same edge.
         if (row_q == 2'd3) begin
            frame_cur_d = snap_d;
            frame_end_d = 1'b1;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // Debounce one edge after frame end; accept only on reaching DEBOUNCE.
      if (frame_end_q) begin
         frame_prev_d = frame_cur_q;
         if (frame_cur_q == frame_prev_q) begin
            if (stable_q != STABLE_MAX) begin
               stable_d = stable_q + 4'd1;
               accept_d = (stable_q == STABLE_MAX - 4'd1);
            end
         end else begin
            stable_d = '0;
         end
      end

      // frame_prev now holds the accepted frame.
      if (accept_q) begin
         case (state_q)
            S_IDLE: begin
               if (pc == 5'd1) begin
                  state_d     = S_PRESSED;
                  key_code_d  = lowest_set(frame_prev_q);
                  key_valid_d = 1'b1;
               end else if (pc >= 5'd2) begin
                  state_d = S_BLOCKED;
               end
            end
            // A different single key without a release is roll-over, not a press.
            S_PRESSED: begin
               if (pc == 5'd0)      state_d = S_IDLE;
               else if (pc >= 5'd2) state_d = S_BLOCKED;
            end
            S_BLOCKED: begin
               if (pc == 5'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      row_out_d   = ~(4'b0001 << row_d);
      key_held_d  = (state_d == S_PRESSED);
      multi_err_d = (state_d == S_BLOCKED);

      if (!clr) begin
         col_meta_d   = 4'hF;
         col_s_d      = 4'hF;
         cnt_d        = '0;
         row_d        = 2'd0;
         row_out_d    = 4'b1110;
         snap_d       = '0;
         frame_cur_d  = '0;
         frame_end_d  = 1'b0;
         frame_prev_d = '0;
         stable_d     = '0;
         accept_d     = 1'b0;
         state_d      = S_IDLE;
         key_code_d   = '0;
         key_valid_d  = 1'b0;
         key_held_d   = 1'b0;
         multi_err_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_meta_q   <= 4'hF;
         col_s_q      <= 4'hF;
         cnt_q        <= '0;
         row_q        <= 2'd0;
         row_out_q    <= 4'b1110;
         snap_q       <= '0;
         frame_cur_q  <= '0;
         frame_end_q  <= 1'b0;
         frame_prev_q <= '0;
         stable_q     <= '0;
         accept_q     <= 1'b0;
         state_q      <= S_IDLE;
         key_code_q   <= '0;
         key_valid_q  <= 1'b0;
         key_held_q   <= 1'b0;
         multi_err_q  <= 1'b0;
      end else begin
         col_meta_q   <= col_meta_d;
         col_s_q      <= col_s_d;
         cnt_q        <= cnt_d;
         row_q        <= row_d;
         row_out_q    <= row_out_d;
         snap_q       <= snap_d;
         frame_cur_q  <= frame_cur_d;
         frame_end_q  <= frame_end_d;
         frame_prev_q <= frame_prev_d;
         stable_q     <= stable_d;
         accept_q     <= accept_d;
         state_q      <= state_d;
         key_code_q   <= key_code_d;
         key_valid_q  <= key_valid_d;
         key_held_q   <= key_held_d;
         multi_err_q  <= multi_err_d;
      end
   end

   assign row_out   = row_out_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign multi_err = multi_err_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner
//   Bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE=3 (16-clock
//   frames). A switch-matrix model pulls col_in[c] low when a pressed key's
//   row is driven. Strobes are checked against a queue of expected codes and
//   cycles.
module tb_keypad_matrix_scanner;

   logic        clk;
   logic        rst;
   logic        clr;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic        multi_err;
   logic [15:0] keys;
   int          cyc;
   int          n_vec;
   int          n_err;

   typedef struct {
      logic [3:0] code;
      int         at;
   } sb_t;

   typedef struct {
      int         at;
      logic [3:0] exp_row;
   } row_vec_t;

   typedef struct {
      logic [3:0] key;
      logic [3:0] exp_code;
   } key_vec_t;

   sb_t sb[$];

   keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .col_in    (col_in),
      .row_out   (row_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .multi_err (multi_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
   end

   // Clock edges since the last reset/clear; frame ends fall on multiples of 16.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      cyc <= 0;
      else if (!clr) cyc <= 0;
      else           cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      sb_t e;
      @(negedge clk);
      if (key_valid === 1'b1) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL strobe: unexpected key_valid code=%0d at cycle %0d", key_code, cyc);
         end else begin
            e = sb.pop_front();
            if (key_code !== e.code || (e.at >= 0 && cyc != e.at)) begin
               n_err++;
               $display("FAIL strobe: code=%0d cycle=%0d, expected code=%0d cycle=%0d",
                        key_code, cyc, e.code, e.at);
            end
         end
      end
   endtask

   task automatic wait_until(input int target);
      int n;
      n = 0;
      while (cyc < target && n < 4000) begin
         step();
         n++;
      end
      if (cyc != target) begin
         n_vec++;
         n_err++;
         $display("FAIL wait: cycle %0d not reached, now %0d", target, cyc);
      end
   endtask

   task automatic align(output int f0);
      int n;
      n = 0;
      while ((cyc % 16) != 0 && n < 32) begin
         step();
         n++;
      end
      f0 = cyc;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_row_out"},   16'(row_out),   16'hE);
      chk({tag, "_key_code"},  16'(key_code),  16'h0);
      chk({tag, "_key_valid"}, 16'(key_valid), 16'h0);
      chk({tag, "_key_held"},  16'(key_held),  16'h0);
      chk({tag, "_multi_err"}, 16'(multi_err), 16'h0);
   endtask

   initial begin
      row_vec_t rt[6];
      key_vec_t kt[4];
      int f0;

      rt[0] = '{3,  4'b1110};
      rt[1] = '{4,  4'b1101};
      rt[2] = '{8,  4'b1011};
      rt[3] = '{12, 4'b0111};
      rt[4] = '{15, 4'b0111};
      rt[5] = '{16, 4'b1110};
      kt[0] = '{4'd6,  4'd6};
      kt[1] = '{4'd0,  4'd0};
      kt[2] = '{4'd15, 4'd15};
      kt[3] = '{4'd11, 4'd11};

      n_vec = 0;
      n_err = 0;
      rst   = 1'b0;
      clr   = 1'b1;
      keys  = '0;
      step();
      step();
      chk_reset_outputs("reset");
      rst = 1'b1;

      for (int i = 0; i < 6; i++) begin
         wait_until(rt[i].at);
         chk("row_scan", 16'(row_out), 16'(rt[i].exp_row));
      end

      // Single keys pressed and released on frame boundaries.
      for (int i = 0; i < 4; i++) begin
         align(f0);
         keys = 16'(1) << kt[i].key;
         sb.push_back('{kt[i].exp_code, f0 + 66});
         wait_until(f0 + 65);
         chk("press_held_early", 16'(key_held), 16'h0);
         wait_until(f0 + 66);
         chk("press_held", 16'(key_held), 16'h1);
         chk("press_code", 16'(key_code), 16'(kt[i].exp_code));
         chk("press_multi", 16'(multi_err), 16'h0);
         align(f0);
         keys = '0;
         wait_until(f0 + 65);
         chk("release_held_early", 16'(key_held), 16'h1);
         wait_until(f0 + 66);
         chk("release_held", 16'(key_held), 16'h0);
         chk("release_code_kept", 16'(key_code), 16'(kt[i].exp_code));
      end

      // Chatter on key 9, then a steady hold.
      align(f0);
      for (int i = 0; i < 9; i++) begin
         keys[9] = ~keys[9];
         repeat (24) step();
      end
      align(f0);
      keys = 16'h0200;
      sb.push_back('{4'd9, -1});
      wait_until(f0 + 80);
      chk("chatter_held", 16'(key_held), 16'h1);
      chk("chatter_code", 16'(key_code), 16'd9);
      chk("chatter_strobe_seen", 16'(sb.size()), 16'h0);
      align(f0);
      keys = '0;
      wait_until(f0 + 66);
      chk("chatter_release", 16'(key_held), 16'h0);

      // Two keys, then one of them, then none, then a fresh press.
      align(f0);
      keys = 16'h8001;
      wait_until(f0 + 66);
      chk("multi_err_set", 16'(multi_err), 16'h1);
      chk("multi_no_held", 16'(key_held), 16'h0);
      align(f0);
      keys = 16'h0001;
      wait_until(f0 + 82);
      chk("multi_stays_blocked", 16'(multi_err), 16'h1);
      chk("multi_still_no_held", 16'(key_held), 16'h0);
      align(f0);
      keys = '0;
      wait_until(f0 + 65);
      chk("multi_clear_early", 16'(multi_err), 16'h1);
      wait_until(f0 + 66);
      chk("multi_clear", 16'(multi_err), 16'h0);
      align(f0);
      keys = 16'h0008;
      sb.push_back('{4'd3, f0 + 66});
      wait_until(f0 + 66);
      chk("after_multi_code", 16'(key_code), 16'd3);
      chk("after_multi_held", 16'(key_held), 16'h1);
      align(f0);
      keys = '0;
      wait_until(f0 + 66);

      // Roll-over from key 5 to key 10 is not a new press.
      align(f0);
      keys = 16'(1) << 5;
      sb.push_back('{4'd5, f0 + 66});
      wait_until(f0 + 66);
      chk("roll_first_code", 16'(key_code), 16'd5);
      align(f0);
      keys = 16'(1) << 10;
      wait_until(f0 + 82);
      chk("roll_code_kept", 16'(key_code), 16'd5);
      chk("roll_held", 16'(key_held), 16'h1);
      align(f0);
      keys = '0;
      wait_until(f0 + 66);
      chk("roll_release", 16'(key_held), 16'h0);
      align(f0);
      keys = 16'(1) << 10;
      sb.push_back('{4'd10, f0 + 66});
      wait_until(f0 + 66);
      chk("roll_new_code", 16'(key_code), 16'd10);
      align(f0);
      keys = '0;
      wait_until(f0 + 66);

      // Asynchronous reset during the row-2 phase, two frames into debounce.
      align(f0);
      keys = 16'(1) << 4;
      wait_until(f0 + 41);
      chk("pre_rst_row", 16'(row_out), 16'hB);
      rst = 1'b0;
      step();
      step();
      chk_reset_outputs("mid_rst");
      rst = 1'b1;
      sb.push_back('{4'd4, 66});
      wait_until(65);
      chk("rst_accept_early", 16'(key_held), 16'h0);
      wait_until(66);
      chk("rst_accept_held", 16'(key_held), 16'h1);
      chk("rst_accept_code", 16'(key_code), 16'd4);
      align(f0);
      keys = '0;
      wait_until(f0 + 66);
      chk("rst_release", 16'(key_held), 16'h0);

      // Same with the synchronous clear.
      align(f0);
      keys = 16'(1) << 4;
      wait_until(f0 + 41);
      clr = 1'b0;
      step();
      chk_reset_outputs("mid_clr");
      clr = 1'b1;
      sb.push_back('{4'd4, 66});
      wait_until(65);
      chk("clr_accept_early", 16'(key_held), 16'h0);
      wait_until(66);
      chk("clr_accept_held", 16'(key_held), 16'h1);
      chk("clr_accept_code", 16'(key_code), 16'd4);
      align(f0);
      keys = '0;
      wait_until(f0 + 66);
      chk("clr_release", 16'(key_held), 16'h0);
      chk("scoreboard_empty", 16'(sb.size()), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
